alu_ctrl_fsm: RTL and testbench

- Multicycle control sequencer that drives the 32-bit ALU's operand-select, operation-code and shift-amount inputs.
- Consumes the ALU's zero and result outputs.
- Accepts one MIPS instruction at a time over a valid/ready handshake, decodes it and sequences the ALU, data memory and register-file write-back.
- Resolves branches from the ALU zero flag.

---
 rtl/alu_ctrl_pkg.sv | 56 +++++
 rtl/alu_ctrl_if.sv | 36 +++
 rtl/alu_ctrl_decode.sv | 62 ++++++
 rtl/alu_ctrl_fsm.sv | 129 ++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU control sequencer.
// Optional extended ops (NOT/INC/DEC) are enabled with ALU_CTRL_EXT_OPS_EN.
package alu_ctrl_pkg;

  // ALU operation codes
  localparam logic [3:0] OP_NOT = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_DEC = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_INC = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1010;
  localparam logic [3:0] OP_SRL = 4'b1011;
  localparam logic [3:0] OP_LUI = 4'b1100;

  // MIPS primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
`ifdef ALU_CTRL_EXT_OPS_EN
  localparam logic [5:0] FN_NOT  = 6'h30;
  localparam logic [5:0] FN_INC  = 6'h31;
  localparam logic [5:0] FN_DEC  = 6'h32;
`endif

  // Operand-B select
  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_SEXT = 2'd1;
  localparam logic [1:0] SRCB_ZEXT = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_FIN} state_t;
  typedef enum logic [2:0] {CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_ILLEGAL} cls_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction handshake, ALU, data-memory and write-back signals of the sequencer.
interface alu_ctrl_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic               instr_valid;
  logic               instr_ready;
  logic [31:0]        instr;
  logic [3:0]         alu_oper;
  logic [SHAMT_W-1:0] alu_shift;
  logic [1:0]         alu_srcb_sel;
  logic               alu_zero;
  logic [DATA_W-1:0]  alu_result;
  logic               mem_req;
  logic               mem_we;
  logic [DATA_W-1:0]  mem_addr;
  logic               mem_ack;
  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic               rf_wsel;
  logic               branch_taken;
  logic               illegal;
  logic               done;

  modport slave (
    input  instr_valid, instr, alu_zero, alu_result, mem_ack,
    output instr_ready, alu_oper, alu_shift, alu_srcb_sel, mem_req, mem_we,
           mem_addr, rf_we, rf_waddr, rf_wsel, branch_taken, illegal, done
  );

  modport master (
    output instr_valid, instr, alu_zero, alu_result, mem_ack,
    input  instr_ready, alu_oper, alu_shift, alu_srcb_sel, mem_req, mem_we,
           mem_addr, rf_we, rf_waddr, rf_wsel, branch_taken, illegal, done
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS decode into ALU controls, instruction class and destination.
// ALU_CTRL_EXT_OPS_EN adds R-type NOT/INC/DEC (funct 0x30-0x32).
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int SHAMT_W = 5
) (
  input  logic [31:0]        instr,
  output logic [3:0]         oper,
  output logic [SHAMT_W-1:0] shift,
  output logic [1:0]         srcb,
  output cls_t               cls,
  output logic [4:0]         dest
);

  // rs only feeds the register file, never the sequencer
  logic unused_rs;
  assign unused_rs = ^instr[25:21];

  // Opcode/funct lookup; anything unlisted stays ILLEGAL
  always_comb begin
    oper  = OP_ADD;
    shift = '0;
    srcb  = SRCB_RT;
    cls   = CL_ILLEGAL;
    dest  = instr[20:16];
    case (instr[31:26])
      OPC_RTYPE: begin
        dest = instr[15:11];
        cls  = CL_ALU;
        case (instr[5:0])
          FN_ADD:          oper = OP_ADD;
          FN_SUB:          oper = OP_SUB;
          FN_AND:          oper = OP_AND;
          FN_OR:           oper = OP_OR;
          FN_XOR:          oper = OP_XOR;
          FN_SLT, FN_SLTU: oper = OP_SLT;
          FN_SLL: begin oper = OP_SLL; shift = SHAMT_W'(instr[10:6]); end
          FN_SRL: begin oper = OP_SRL; shift = SHAMT_W'(instr[10:6]); end
`ifdef ALU_CTRL_EXT_OPS_EN
          FN_NOT:          oper = OP_NOT;
          FN_INC:          oper = OP_INC;
          FN_DEC:          oper = OP_DEC;
`endif
          default:         cls  = CL_ILLEGAL;
        endcase
      end
      OPC_ADDI: begin oper = OP_ADD; srcb = SRCB_SEXT; cls = CL_ALU;    end
      OPC_SLTI: begin oper = OP_SLT; srcb = SRCB_SEXT; cls = CL_ALU;    end
      OPC_ANDI: begin oper = OP_AND; srcb = SRCB_ZEXT; cls = CL_ALU;    end
      OPC_ORI:  begin oper = OP_OR;  srcb = SRCB_ZEXT; cls = CL_ALU;    end
      OPC_XORI: begin oper = OP_XOR; srcb = SRCB_ZEXT; cls = CL_ALU;    end
      OPC_LUI:  begin oper = OP_LUI; srcb = SRCB_ZEXT; cls = CL_ALU;    end
      OPC_LW:   begin oper = OP_ADD; srcb = SRCB_SEXT; cls = CL_LOAD;   end
      OPC_SW:   begin oper = OP_ADD; srcb = SRCB_SEXT; cls = CL_STORE;  end
      OPC_BEQ, OPC_BNE:
                begin oper = OP_SUB; srcb = SRCB_RT;   cls = CL_BRANCH; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multicycle sequencer: accepts one instruction, drives the ALU, data memory and
// register write-back, and resolves branches from the ALU zero flag.
// ALU_CTRL_EXT_OPS_EN (in the decoder) enables extended R-type ops.
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input logic       clk,
  input logic       reset,
  alu_ctrl_if.slave bus
);

  state_t             state, state_nxt;
  logic [31:0]        instr_q;
  logic [3:0]         oper_q;
  logic [SHAMT_W-1:0] shift_q;
  logic [1:0]         srcb_q;
  cls_t               cls_q;
  logic [4:0]         dest_q;
  logic [DATA_W-1:0]  result_q;
  logic               zero_q;

  logic [3:0]         dec_oper;
  logic [SHAMT_W-1:0] dec_shift;
  logic [1:0]         dec_srcb;
  cls_t               dec_cls;
  logic [4:0]         dec_dest;

  alu_ctrl_decode #(.SHAMT_W(SHAMT_W)) u_decode (
    .instr (instr_q),
    .oper  (dec_oper),
    .shift (dec_shift),
    .srcb  (dec_srcb),
    .cls   (dec_cls),
    .dest  (dec_dest)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Instruction latch, decoded fields and captured ALU outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q  <= '0;
      oper_q   <= OP_ADD;
      shift_q  <= '0;
      srcb_q   <= SRCB_RT;
      cls_q    <= CL_ALU;
      dest_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.instr_valid) instr_q <= bus.instr;
      if (state == S_DECODE) begin
        oper_q  <= dec_oper;
        shift_q <= dec_shift;
        srcb_q  <= dec_srcb;
        cls_q   <= dec_cls;
        dest_q  <= dec_dest;
      end
      if (state == S_EXEC) begin
        result_q <= bus.alu_result;
        zero_q   <= bus.alu_zero;
      end
    end
  end

  // Address and destination come straight from their registers
  assign bus.mem_addr = result_q;
  assign bus.rf_waddr = dest_q;

  // Next state and per-state outputs; ALU inputs idle at ADD/0/rt
  always_comb begin
    state_nxt        = state;
    bus.instr_ready  = 1'b0;
    bus.alu_oper     = OP_ADD;
    bus.alu_shift    = '0;
    bus.alu_srcb_sel = SRCB_RT;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.rf_we        = 1'b0;
    bus.rf_wsel      = 1'b0;
    bus.branch_taken = 1'b0;
    bus.illegal      = 1'b0;
    bus.done         = 1'b0;
    case (state)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_nxt = S_DECODE;
      end
      S_DECODE: state_nxt = (dec_cls == CL_ILLEGAL) ? S_FIN : S_EXEC;
      S_EXEC: begin
        bus.alu_oper     = oper_q;
        bus.alu_shift    = shift_q;
        bus.alu_srcb_sel = srcb_q;
        case (cls_q)
          CL_ALU:            state_nxt = S_WB;
          CL_LOAD, CL_STORE: state_nxt = S_MEM;
          default:           state_nxt = S_FIN;
        endcase
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (cls_q == CL_STORE);
        if (bus.mem_ack) state_nxt = (cls_q == CL_LOAD) ? S_WB : S_FIN;
      end
      S_WB: begin
        bus.rf_we   = (dest_q != 5'd0);
        bus.rf_wsel = (cls_q == CL_LOAD);
        bus.done    = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_FIN: begin
        bus.done    = 1'b1;
        bus.illegal = (cls_q == CL_ILLEGAL);
        // opcode bit 0 separates bne (taken on !zero) from beq (taken on zero)
        bus.branch_taken = (cls_q == CL_BRANCH) && (instr_q[26] ? !zero_q : zero_q);
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: a retire monitor pops expected results
// from a scoreboard; scenario tasks check ALU/memory controls inline.
module tb_alu_ctrl_fsm;
  import alu_ctrl_pkg::*;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_ctrl_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) bus();

  alu_ctrl_fsm #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       rf_we;
    logic [4:0] waddr;
    logic       wsel;
    logic       br;
    logic       ill;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int passed = 0, total = 0;
  int cyc = 0, acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input logic we, input logic [4:0] wa, input logic ws,
                          input logic br, input logic ill, input int lat);
    exp_t e;
    e.rf_we = we; e.waddr = wa; e.wsel = ws; e.br = br; e.ill = ill; e.lat = lat;
    sb.push_back(e);
  endtask

  // Offer one instruction in IDLE; returns #1 after the accept edge (DECODE)
  task automatic issue(input logic [31:0] w, input logic [31:0] res, input logic z);
    bus.instr = w; bus.instr_valid = 1'b1;
    bus.alu_result = res; bus.alu_zero = z;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Bounded wait for done, then one more cycle back to IDLE
  task automatic wait_done(input string name);
    int n = 0;
    while (bus.done !== 1'b1 && n < 40) begin step(); n++; end
    if (bus.done !== 1'b1) begin
      total++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, bus.done, n);
    end
    step();
  endtask

  // Retire monitor: pops and compares whenever done pulses
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.done === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL retire_unexpected: done=1 with empty scoreboard");
        end else begin
          passed++;
          e = sb.pop_front();
          total++;
          if ({bus.rf_we, bus.branch_taken, bus.illegal} !== {e.rf_we, e.br, e.ill})
            $display("FAIL retire_flags: we/br/ill=%b%b%b required %b%b%b",
                     bus.rf_we, bus.branch_taken, bus.illegal, e.rf_we, e.br, e.ill);
          else passed++;
          total++;
          if (cyc - acc_cyc + 1 != e.lat)
            $display("FAIL retire_latency: %0d required %0d", cyc - acc_cyc + 1, e.lat);
          else passed++;
          if (e.rf_we) begin
            total++;
            if ({bus.rf_waddr, bus.rf_wsel} !== {e.waddr, e.wsel})
              $display("FAIL retire_wb: waddr=%0d wsel=%b required %0d %b",
                       bus.rf_waddr, bus.rf_wsel, e.waddr, e.wsel);
            else passed++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.alu_zero = 1'b0;
    bus.alu_result = '0; bus.mem_ack = 1'b0;
    repeat (3) step();
    total++;
    if ({bus.instr_ready, bus.mem_req, bus.mem_we, bus.rf_we, bus.branch_taken, bus.illegal, bus.done} !== 7'b1000000)
      $display("FAIL reset_ctrl: rdy/req/we/rfwe/br/ill/done=%b required 1000000",
               {bus.instr_ready, bus.mem_req, bus.mem_we, bus.rf_we, bus.branch_taken, bus.illegal, bus.done});
    else passed++;
    total++;
    if ({bus.alu_oper, bus.alu_shift, bus.alu_srcb_sel} !== {4'b0101, 5'd0, 2'd0})
      $display("FAIL reset_alu: oper=%b shift=%0d srcb=%0d required 0101 0 0",
               bus.alu_oper, bus.alu_shift, bus.alu_srcb_sel);
    else passed++;
    total++;
    if (bus.mem_addr !== 32'd0 || bus.rf_waddr !== 5'd0)
      $display("FAIL reset_addr: mem_addr=%h rf_waddr=%0d required 0 0", bus.mem_addr, bus.rf_waddr);
    else passed++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu_add();
    issue(32'h00221820, 32'h42, 1'b0);
    push_exp(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 3);
    total++;
    if (bus.instr_ready !== 1'b0) $display("FAIL add_busy_ready: %b required 0", bus.instr_ready);
    else passed++;
    step();
    total++;
    if ({bus.alu_oper, bus.alu_srcb_sel} !== {4'b0101, 2'd0})
      $display("FAIL add_exec: oper=%b srcb=%0d required 0101 0", bus.alu_oper, bus.alu_srcb_sel);
    else passed++;
    wait_done("add");
  endtask

  task automatic test_shift();
    logic [31:0] w [2] = '{32'h00022140, 32'h00020140};
    for (int i = 0; i < 2; i++) begin
      issue(w[i], 32'h40, 1'b0);
      push_exp(i == 0, (i == 0) ? 5'd4 : 5'd0, 1'b0, 1'b0, 1'b0, 3);
      step();
      total++;
      if ({bus.alu_oper, bus.alu_shift} !== {4'b1010, 5'd5})
        $display("FAIL sll_exec%0d: oper=%b shift=%0d required 1010 5", i, bus.alu_oper, bus.alu_shift);
      else passed++;
      step();
      total++;
      if (bus.rf_we !== (i == 0))
        $display("FAIL sll_wb%0d: rf_we=%b required %b", i, bus.rf_we, i == 0);
      else passed++;
      wait_done("sll");
    end
  endtask

  task automatic test_branch();
    logic [31:0] w [4] = '{32'h10220003, 32'h14220003, 32'h14220003, 32'h10220003};
    logic        z [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue(w[i], z[i] ? 32'd0 : 32'd7, z[i]);
      push_exp(1'b0, 5'd0, 1'b0, t[i], 1'b0, 3);
      step();
      total++;
      if ({bus.alu_oper, bus.alu_srcb_sel} !== {4'b0110, 2'd0})
        $display("FAIL branch_exec%0d: oper=%b srcb=%0d required 0110 0", i, bus.alu_oper, bus.alu_srcb_sel);
      else passed++;
      wait_done("branch");
    end
  endtask

  task automatic test_load_store();
    // lw $5,8($1) with ack on the 4th MEM cycle
    issue(32'h8C250008, 32'h1008, 1'b0);
    push_exp(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 7);
    step();
    total++;
    if ({bus.alu_oper, bus.alu_srcb_sel} !== {4'b0101, 2'd1})
      $display("FAIL lw_exec: oper=%b srcb=%0d required 0101 1", bus.alu_oper, bus.alu_srcb_sel);
    else passed++;
    step();
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h1008})
        $display("FAIL lw_mem%0d: req=%b we=%b addr=%h required 1 0 00001008",
                 i, bus.mem_req, bus.mem_we, bus.mem_addr);
      else passed++;
      if (i == 3) bus.mem_ack = 1'b1;
      step();
    end
    bus.mem_ack = 1'b0;
    wait_done("lw");
    // sw, acked immediately
    issue(32'hAC250008, 32'h2000, 1'b0);
    push_exp(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4);
    step(); step();
    total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 32'h2000})
      $display("FAIL sw_mem: req=%b we=%b addr=%h required 1 1 00002000",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    else passed++;
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    wait_done("sw");
  endtask

  task automatic test_ext_illegal();
`ifdef ALU_CTRL_EXT_OPS_EN
    issue(32'h00221831, 32'h5, 1'b0);
    push_exp(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 3);
    step();
    total++;
    if (bus.alu_oper !== 4'b0111) $display("FAIL inc_exec: oper=%b required 0111", bus.alu_oper);
    else passed++;
    wait_done("inc");
`else
    issue(32'h00221831, 32'h5, 1'b0);
    push_exp(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2);
    step();
    total++;
    if ({bus.mem_req, bus.rf_we, bus.alu_oper} !== {1'b0, 1'b0, 4'b0101})
      $display("FAIL inc_illegal_fin: req=%b rf_we=%b oper=%b required 0 0 0101",
               bus.mem_req, bus.rf_we, bus.alu_oper);
    else passed++;
    wait_done("inc_illegal");
`endif
    // unknown opcode is always illegal
    issue(32'hFC000000, 32'h0, 1'b0);
    push_exp(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 2);
    wait_done("bad_opcode");
  endtask

  task automatic test_reset_mid_mem();
    issue(32'h8C250008, 32'h1008, 1'b0);
    step(); step();
    total++;
    if (bus.mem_req !== 1'b1) $display("FAIL midmem_req: %b required 1", bus.mem_req);
    else passed++;
    reset = 1'b1;
    step();
    total++;
    if ({bus.instr_ready, bus.mem_req, bus.rf_we, bus.branch_taken, bus.illegal, bus.done} !== 6'b100000)
      $display("FAIL midmem_reset: rdy/req/rfwe/br/ill/done=%b required 100000",
               {bus.instr_ready, bus.mem_req, bus.rf_we, bus.branch_taken, bus.illegal, bus.done});
    else passed++;
    step(); step();
    reset = 1'b0;
    step();
    total++;
    if ({bus.instr_ready, bus.mem_req, bus.mem_addr} !== {1'b1, 1'b0, 32'd0})
      $display("FAIL midmem_after: rdy=%b req=%b addr=%h required 1 0 0",
               bus.instr_ready, bus.mem_req, bus.mem_addr);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [13] = '{32'h20270005, 32'h28280010, 32'h34290F0F, 32'h3C0A1234,
                            32'h302B00FF, 32'h382C0001, 32'h00221822, 32'h00221824,
                            32'h00221825, 32'h00221826, 32'h0022182A, 32'h0022182B,
                            32'h00022142};
    logic [3:0]  op [13] = '{4'b0101, 4'b1000, 4'b0011, 4'b1100, 4'b0001, 4'b0010,
                             4'b0110, 4'b0001, 4'b0011, 4'b0010, 4'b1000, 4'b1000, 4'b1011};
    logic [1:0]  sb_sel [13] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0,
                                 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [4:0]  wa [13] = '{5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd3, 5'd3,
                             5'd3, 5'd3, 5'd3, 5'd3, 5'd4};
    logic [4:0]  sh [13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                             5'd0, 5'd0, 5'd0, 5'd0, 5'd5};
    for (int i = 0; i < 13; i++) begin
      issue(w[i], 32'h100 + i, 1'b0);
      push_exp(1'b1, wa[i], 1'b0, 1'b0, 1'b0, 3);
      step();
      total++;
      if ({bus.alu_oper, bus.alu_srcb_sel, bus.alu_shift} !== {op[i], sb_sel[i], sh[i]})
        $display("FAIL b2b_exec%0d: oper=%b srcb=%0d shift=%0d required %b %0d %0d",
                 i, bus.alu_oper, bus.alu_srcb_sel, bus.alu_shift, op[i], sb_sel[i], sh[i]);
      else passed++;
      wait_done("b2b");
    end
  endtask

  initial begin
    reset = 1'b1;
    fork monitor(); join_none
    test_reset();
    test_alu_add();
    test_shift();
    test_branch();
    test_load_store();
    test_ext_illegal();
    test_reset_mid_mem();
    test_back_to_back();
    repeat (2) step();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
